// File: rtl/voice_mixer.sv
// voice_mixer: per-sample mixer between the voice oscillators and the codec
// interface. On each rising edge of the codec LR clock it snapshots the voice
// outputs, sums them one voice per clock, applies the master volume, and
// saturates to 16-bit signed. The result is held for LDATA/RDATA.
//
// Handshake: sample_valid is a single-cycle strobe with no ready. It is high in
// the cycle where sample_out first carries the new sample. sample_out then
// holds that value until the next strobe.
module voice_mixer #(
  parameter int NUM_VOICES = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    lrck,
  input  logic [16*NUM_VOICES-1:0] voice_in,
  input  logic [7:0]              master_vol,
  input  logic                    mute,
  input  logic                    clr_flags,
  output logic [15:0]             sample_out,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    clip,
  output logic                    overrun,
  output logic [1:0]              state_dbg
);

  // Accumulator wide enough for NUM_VOICES full-scale voices.
  localparam int SUM_W = 16 + $clog2(NUM_VOICES);
  // Product of the accumulator and the 9-bit signed (zero-extended) volume.
  localparam int PW    = SUM_W + 9;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic signed [PW-1:0] MAX_S = PW'(32767);
  localparam logic signed [PW-1:0] MIN_S = PW'(-32768);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t state, next_state;

  logic s1, s2, s3;
  logic lrck_rise;

  logic signed [15:0]      snap [NUM_VOICES];
  logic [7:0]              vol_snap;
  logic                    mute_snap;
  logic signed [SUM_W-1:0] acc;
  logic [IDX_W-1:0]        idx;
  logic signed [PW-1:0]    scaled;
  logic signed [PW-1:0]    prod_c;
  logic                    last_voice;
  logic [15:0]             sat_val;
  logic                    sat_clip;

  // Three-flop synchroniser for the asynchronous LR clock; rising edge from s2/s3.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= lrck;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lrck_rise  = s2 & ~s3;
  assign last_voice = (idx == IDX_W'(NUM_VOICES - 1));

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next-state logic: one pass IDLE -> ACCUM (N cycles) -> SCALE -> OUTPUT.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (lrck_rise)  next_state = ACCUM;
      ACCUM:   if (last_voice) next_state = SCALE;
      SCALE:   next_state = OUTPUT;
      OUTPUT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: busy flag and state visibility for debug.
  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // Signed product. The volume is zero-extended so 0xFF stays positive.
  always_comb begin
    prod_c = PW'(acc) * PW'($signed({1'b0, vol_snap}));
  end

  // Saturate the scaled value to 16-bit signed and flag whether it clipped.
  always_comb begin
    sat_val  = scaled[15:0];
    sat_clip = 1'b0;
    if (scaled > MAX_S) begin
      sat_val  = 16'h7FFF;
      sat_clip = 1'b1;
    end else if (scaled < MIN_S) begin
      sat_val  = 16'h8000;
      sat_clip = 1'b1;
    end
  end

  // Datapath: snapshot on the LR edge, accumulate one voice per cycle, then scale.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < NUM_VOICES; k++) snap[k] <= '0;
      vol_snap  <= '0;
      mute_snap <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      scaled    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lrck_rise) begin
            for (int k = 0; k < NUM_VOICES; k++) snap[k] <= voice_in[16*k +: 16];
            vol_snap  <= master_vol;
            mute_snap <= mute;
            acc       <= '0;
            idx       <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + SUM_W'(snap[idx]);
          idx <= idx + 1'b1;
        end
        SCALE: begin
          // Arithmetic shift, so negative results round toward -inf.
          scaled <= prod_c >>> 8;
        end
        default: ;
      endcase
    end
  end

  // Output register, valid strobe, and sticky flags. A set wins over a same-cycle clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      clip         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= (state == OUTPUT);
      if (state == OUTPUT) sample_out <= mute_snap ? 16'h0000 : sat_val;

      if ((state == OUTPUT) && sat_clip && !mute_snap) clip <= 1'b1;
      else if (clr_flags)                              clip <= 1'b0;

      if (lrck_rise && (state != IDLE)) overrun <= 1'b1;
      else if (clr_flags)               overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer with four voices: directed corner cases, randomized
// mixes checked against an arithmetic model, overrun, reset abort, and flag
// clear priority.
module tb_voice_mixer;

  localparam int N = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          lrck = 1'b0;
  logic [16*N-1:0] voice_in = '0;
  logic [7:0]    master_vol = '0;
  logic          mute = 1'b0;
  logic          clr_flags = 1'b0;
  logic [15:0]   sample_out;
  logic          sample_valid;
  logic          busy;
  logic          clip;
  logic          overrun;
  logic [1:0]    state_dbg;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  logic [15:0] last_sample = '0;
  logic [15:0] exp_q[$];

  voice_mixer #(.NUM_VOICES(N)) dut (
    .Clk(Clk), .Reset(Reset), .lrck(lrck), .voice_in(voice_in),
    .master_vol(master_vol), .mute(mute), .clr_flags(clr_flags),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
    .clip(clip), .overrun(overrun), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 Clk = ~Clk;

  // Count valid strobes and remember the last sample delivered.
  always @(posedge Clk) begin
    if (sample_valid === 1'b1) begin
      valid_cnt++;
      last_sample = sample_out;
    end
  end

  // Reference model: plain integer sum, gain, floor divide by 256, saturate.
  function automatic void mix_model(input logic [16*N-1:0] v, input logic [7:0] vol,
                                    input logic m, output logic [15:0] o, output logic c);
    int sum, prod, q;
    sum = 0;
    for (int k = 0; k < N; k++) sum += int'($signed(v[16*k +: 16]));
    prod = sum * int'(vol);
    if (prod >= 0) q = prod / 256;
    else           q = -((-prod + 255) / 256);
    c = 1'b0;
    if (m)               o = 16'h0000;
    else if (q > 32767)  begin o = 16'h7FFF; c = 1'b1; end
    else if (q < -32768) begin o = 16'h8000; c = 1'b1; end
    else                 o = 16'(q);
  endfunction

  // Driver: one LR rising edge, wait (bounded) for the strobe, return result and latency.
  task automatic do_sample(input logic [16*N-1:0] v, input logic [7:0] vol, input logic m,
                           output logic [15:0] o, output int lat, output logic c);
    @(negedge Clk);
    voice_in = v; master_vol = vol; mute = m; lrck = 1'b1;
    lat = -1; o = 'x; c = 'x;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge Clk); #1;
      if (sample_valid === 1'b1) begin
        lat = cyc; o = sample_out; c = clip;
        break;
      end
    end
    @(negedge Clk); lrck = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic pulse_clr();
    @(negedge Clk); clr_flags = 1'b1;
    @(negedge Clk); clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (sample_out !== 16'h0 || sample_valid !== 1'b0 || busy !== 1'b0 ||
        clip !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset: out=%h valid=%b busy=%b clip=%b ovr=%b, want all 0",
               sample_out, sample_valid, busy, clip, overrun);
    end
    @(negedge Clk); Reset = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_directed();
    logic [16*N-1:0] vt [4];
    logic [7:0]      volt [4];
    logic [15:0] o, eo;
    logic c, ec;
    int lat;
    vt[0] = {N{16'h1000}}; volt[0] = 8'h80;
    vt[1] = {N{16'h7FFF}}; volt[1] = 8'hFF;
    vt[2] = {N{16'h8000}}; volt[2] = 8'hFF;
    vt[3] = {N{16'hFFFF}}; volt[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      pulse_clr();
      mix_model(vt[i], volt[i], 1'b0, eo, ec);
      do_sample(vt[i], volt[i], 1'b0, o, lat, c);
      checks++;
      if (lat != 8) begin
        failures++;
        $display("FAIL directed%0d_latency: got %0d edges, want 8", i, lat);
      end
      checks++;
      if (o !== eo) begin
        failures++;
        $display("FAIL directed%0d_sample: got %h, want %h", i, o, eo);
      end
      checks++;
      if (c !== ec) begin
        failures++;
        $display("FAIL directed%0d_clip: got %b, want %b", i, c, ec);
      end
    end
    // The last clipping case left clip set; the clear must drop it.
    pulse_clr();
    #1;
    checks++;
    if (clip !== 1'b0) begin
      failures++;
      $display("FAIL directed_clr: clip=%b, want 0", clip);
    end
  endtask

  task automatic test_mute();
    logic [15:0] o;
    logic c;
    int lat;
    pulse_clr();
    do_sample({N{16'h7FFF}}, 8'hFF, 1'b1, o, lat, c);
    checks++;
    if (o !== 16'h0000 || c !== 1'b0) begin
      failures++;
      $display("FAIL mute: out=%h clip=%b, want 0000/0", o, c);
    end
  endtask

  task automatic test_random();
    logic [16*N-1:0] v;
    logic [7:0] vol;
    logic m, c, ec;
    logic [15:0] o, eo;
    int lat;
    for (int i = 0; i < 10; i++) begin
      v = {$urandom(), $urandom()};
      vol = 8'($urandom_range(0, 255));
      m = ($urandom_range(0, 7) == 0);
      pulse_clr();
      mix_model(v, vol, m, eo, ec);
      exp_q.push_back(eo);
      do_sample(v, vol, m, o, lat, c);
      eo = exp_q.pop_front();
      checks++;
      if (lat != 8 || o !== eo || c !== ec) begin
        failures++;
        $display("FAIL random%0d: out=%h clip=%b lat=%0d, want %h/%b/8 (v=%h vol=%h m=%b)",
                 i, o, c, lat, eo, ec, v, vol, m);
      end
    end
  endtask

  task automatic test_clr_set_wins();
    int seen;
    pulse_clr();
    @(negedge Clk);
    voice_in = {N{16'h7FFF}}; master_vol = 8'hFF; mute = 1'b0;
    lrck = 1'b1; clr_flags = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge Clk); #1;
      if (sample_valid === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (seen == 0 || clip !== 1'b1) begin
      failures++;
      $display("FAIL clr_set_wins: seen=%0d clip=%b, want strobe and clip 1", seen, clip);
    end
    @(posedge Clk); #1;
    checks++;
    if (clip !== 1'b0) begin
      failures++;
      $display("FAIL clr_next_cycle: clip=%b, want 0", clip);
    end
    @(negedge Clk); clr_flags = 1'b0; lrck = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic test_overrun();
    int cnt0;
    pulse_clr();
    @(negedge Clk);
    voice_in = {N{16'h1000}}; master_vol = 8'h80; mute = 1'b0; lrck = 1'b1;
    cnt0 = valid_cnt;
    repeat (3) @(negedge Clk);          // past edge 2: accumulating
    lrck = 1'b0;
    repeat (2) @(negedge Clk);
    lrck = 1'b1;                        // second rise lands while busy
    voice_in = {$urandom(), $urandom()};
    master_vol = 8'hFF;
    repeat (40) @(negedge Clk);         // lrck stays high
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_flag: got %b, want 1", overrun);
    end
    checks++;
    if (valid_cnt - cnt0 != 1) begin
      failures++;
      $display("FAIL overrun_pulses: got %0d strobes, want 1", valid_cnt - cnt0);
    end
    checks++;
    if (last_sample !== 16'h2000) begin
      failures++;
      $display("FAIL overrun_sample: got %h, want 2000", last_sample);
    end
    pulse_clr();
    #1;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clr: got %b, want 0", overrun);
    end
    lrck = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] o;
    logic c;
    int lat, cnt0;
    do_sample({N{16'h7FFF}}, 8'hFF, 1'b0, o, lat, c);   // leaves clip set, output nonzero
    @(negedge Clk);
    voice_in = {N{16'h1000}}; master_vol = 8'h80; lrck = 1'b1;
    repeat (4) @(negedge Clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_busy_before: busy=%b, want 1", busy);
    end
    Reset = 1'b1; lrck = 1'b0;
    cnt0 = valid_cnt;
    @(posedge Clk); #1;
    checks++;
    if (busy !== 1'b0 || sample_out !== 16'h0 || clip !== 1'b0 ||
        overrun !== 1'b0 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b out=%h clip=%b ovr=%b valid=%b, want all 0",
               busy, sample_out, clip, overrun, sample_valid);
    end
    @(negedge Clk); Reset = 1'b0;
    repeat (20) @(negedge Clk);
    checks++;
    if (valid_cnt != cnt0) begin
      failures++;
      $display("FAIL reset_mid_no_strobe: got %0d strobes, want 0", valid_cnt - cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mute();
    test_clr_set_wins();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
